// File: rtl/axi_slave_read_resp_pop_fsm_pkg.sv
// axi_slave_package: shared response/state enums and default widths for the R-channel pop path
package axi_slave_package;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_t;
  typedef enum logic {IDLE, BURST} pop_state_t;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ID_WIDTH = 4;
  localparam int DEF_LEN_WIDTH = 8;
endpackage

// File: rtl/axi_slave_read_resp_pop_fsm_beat_counter.sv
// beat_counter: load/enable up/down counter (mode=1 counts down) with zero flag; ports clk, rst, load, load_val, en, mode -> count, zero
module beat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             zero
);
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (load) count <= load_val;
    else if (en) count <= mode ? count - 1'b1 : count + 1'b1;
  assign zero = count == '0;
endmodule

// File: rtl/axi_slave_read_resp_pop_fsm.sv
// axi_slave_read_resp_pop_fsm: drains header+data buffers into the AXI4 R channel; ports: header FIFO (hdr_*), data FIFO (data_*), R channel, busy
module axi_slave_read_resp_pop_fsm
  import axi_slave_package::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ID_WIDTH   = DEF_ID_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hdr_empty,
  input  logic [ID_WIDTH-1:0]   hdr_id,
  input  logic [LEN_WIDTH-1:0]  hdr_len,
  input  logic [1:0]            hdr_resp,
  output logic                  hdr_rd_en,
  input  logic                  data_empty,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  data_rd_en,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [ID_WIDTH-1:0]   RID,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  busy
);
  pop_state_t state, state_nx;
  logic [ID_WIDTH-1:0] cur_id;
  resp_t cur_resp;
  logic [LEN_WIDTH-1:0] count;
  logic zero, free;
  assign free = !RVALID || RREADY;
  // pops are suppressed while rst is held so the buffers lose nothing during reset
  always_comb begin
    hdr_rd_en = 1'b0;
    data_rd_en = 1'b0;
    state_nx = state;
    hdr_rd_en = !rst && state == IDLE && !hdr_empty;
    data_rd_en = !rst && state == BURST && free && !data_empty;
    state_nx = hdr_rd_en ? BURST : (data_rd_en && zero) ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      RVALID <= 1'b0;
      RLAST <= 1'b0;
      RDATA <= '0;
      RID <= '0;
      RRESP <= '0;
      cur_id <= '0;
      cur_resp <= OKAY;
    end else begin
      state <= state_nx;
      if (hdr_rd_en) begin
        cur_id <= hdr_id;
        cur_resp <= resp_t'(hdr_resp);
      end
      if (data_rd_en) begin
        RDATA <= data_in;
        RID <= cur_id;
        RRESP <= cur_resp;
        RVALID <= 1'b1;
        RLAST <= zero;
      end else if (RREADY) begin
        RVALID <= 1'b0;
        RLAST <= 1'b0;
      end
    end
  // the beat loaded at count==0 leaves BURST, so the counter never needs to wrap
  beat_counter #(.WIDTH(LEN_WIDTH)) u_cnt (
    .clk(clk),
    .rst(rst),
    .load(hdr_rd_en),
    .load_val(hdr_len),
    .en(data_rd_en && !zero),
    .mode(1'b1),
    .count(count),
    .zero(zero)
  );
  assign busy = state != IDLE || RVALID;
endmodule
